// File: rtl/sparse_mvm_core.sv
// Sparse matrix-vector multiply core: loads x[], accumulates nonzero (row,col,value) beats, streams y[].
// Optional MVM_SAT_EN clamps each result element to the signed DW range instead of wrapping it.
`timescale 1ns/1ps
module sparse_mvm_core #(
    parameter int DIM   = 4,
    parameter int DW    = 8,
    parameter int IW    = (DIM > 2) ? $clog2(DIM) : 1,
    parameter int ACC_W = 2*DW + $clog2(DIM) + 1,
    parameter int CW    = $clog2(DIM*DIM + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [IW-1:0] in_row,
    input  logic [IW-1:0] in_col,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic [CW-1:0] nnz_count,
    output logic          err
);

    typedef enum logic [1:0] {
        S_VEC = 2'd0,
        S_MAT = 2'd1,
        S_OUT = 2'd2
    } state_t;

    localparam logic [IW:0]   DIM_IDX  = (IW+1)'(DIM);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIM - 1);
    localparam logic [CW-1:0] NNZ_MAX  = CW'(DIM * DIM);

    state_t                  state_r;
    state_t                  state_s;
    logic signed [DW-1:0]    x_r   [DIM];
    logic signed [ACC_W-1:0] acc_r [DIM];
    logic [IW-1:0]           vidx_r;
    logic [IW-1:0]           oidx_r;
    logic [CW-1:0]           nnz_r;
    logic                    err_r;

    logic                    accept_s;
    logic                    emit_s;
    logic                    in_range_s;
    logic                    nonzero_s;
    logic signed [DW-1:0]    x_sel_s;
    logic signed [ACC_W-1:0] acc_sel_s;
    logic signed [2*DW-1:0]  prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;

    assign accept_s   = in_valid & ((state_r == S_VEC) | (state_r == S_MAT));
    assign emit_s     = (state_r == S_OUT) & out_ready;
    // Compare with one extra bit so a non-power-of-two DIM flags indices DIM..2^IW-1.
    assign in_range_s = ({1'b0, in_row} < DIM_IDX) & ({1'b0, in_col} < DIM_IDX);
    assign nonzero_s  = (in_data != {DW{1'b0}});

    // Operand and result element selection by index.
    always_comb begin
        x_sel_s   = {DW{1'b0}};
        acc_sel_s = {ACC_W{1'b0}};
        for (int i = 0; i < DIM; i++) begin
            x_sel_s   = (in_col == IW'(i)) ? x_r[i]   : x_sel_s;
            acc_sel_s = (oidx_r == IW'(i)) ? acc_r[i] : acc_sel_s;
        end
        prod_s     = $signed(in_data) * x_sel_s;
        prod_ext_s = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_VEC;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_s   = state_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            S_VEC: begin
                in_ready = 1'b1;
                if (accept_s && (vidx_r == LAST_IDX)) begin
                    state_s = S_MAT;
                end else begin
                    state_s = S_VEC;
                end
            end
            S_MAT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept_s && in_last) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_MAT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (emit_s && (oidx_r == LAST_IDX)) begin
                    state_s = S_VEC;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_VEC;
            end
        endcase
    end

    // Vector load, sparse accumulation and result drain datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vidx_r <= {IW{1'b0}};
            oidx_r <= {IW{1'b0}};
            nnz_r  <= {CW{1'b0}};
            err_r  <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                x_r[i]   <= {DW{1'b0}};
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else begin
            case (state_r)
                S_VEC: begin
                    if (accept_s) begin
                        for (int i = 0; i < DIM; i++) begin
                            if (vidx_r == IW'(i)) begin
                                x_r[i] <= $signed(in_data);
                            end
                        end
                        vidx_r <= (vidx_r == LAST_IDX) ? {IW{1'b0}} : vidx_r + 1'b1;
                    end
                end
                S_MAT: begin
                    if (accept_s) begin
                        if (!in_range_s) begin
                            err_r <= 1'b1;
                        end else if (nonzero_s) begin
                            for (int i = 0; i < DIM; i++) begin
                                if (in_row == IW'(i)) begin
                                    acc_r[i] <= acc_r[i] + prod_ext_s;
                                end
                            end
                            if (nnz_r != NNZ_MAX) begin
                                nnz_r <= nnz_r + 1'b1;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (emit_s) begin
                        if (oidx_r == LAST_IDX) begin
                            oidx_r <= {IW{1'b0}};
                            nnz_r  <= {CW{1'b0}};
                            for (int i = 0; i < DIM; i++) begin
                                acc_r[i] <= {ACC_W{1'b0}};
                            end
                        end else begin
                            oidx_r <= oidx_r + 1'b1;
                        end
                    end
                end
                default: begin
                    vidx_r <= {IW{1'b0}};
                end
            endcase
        end
    end

`ifdef MVM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [DW-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
        logic [DW-1:0] r;
        if (a > SAT_MAX) begin
            r = SAT_MAX[DW-1:0];
        end else if (a < SAT_MIN) begin
            r = SAT_MIN[DW-1:0];
        end else begin
            r = a[DW-1:0];
        end
        return r;
    endfunction

    assign out_data = sat_acc(acc_sel_s);
`else
    logic unused_hi_s;
    assign unused_hi_s = ^acc_sel_s[ACC_W-1:DW];
    assign out_data    = acc_sel_s[DW-1:0];
`endif

    assign out_idx   = oidx_r;
    assign nnz_count = nnz_r;
    assign err       = err_r;

endmodule

// File: tb/tb_sparse_mvm_core.sv
// Scoreboard bench for sparse_mvm_core: DIM=4 main instance plus a DIM=3 instance for index-range checks.
`timescale 1ns/1ps
module tb_sparse_mvm_core;

    typedef struct { int idx; int data; int nnz; } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic [1:0] in_row, in_col;
    logic       in_ready, out_valid, busy, err;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic [4:0] nnz_count;

    logic       d3_in_valid, d3_in_last;
    logic [7:0] d3_in_data;
    logic [1:0] d3_in_row, d3_in_col;
    logic       d3_in_ready, d3_out_valid, d3_busy, d3_err;
    logic [7:0] d3_out_data;
    logic [1:0] d3_out_idx;
    logic [3:0] d3_nnz;

    int   n_checks = 0;
    int   n_err = 0;
    int   rdy_mode = 0;
    int   stall = 0;
    exp_t q[$];
    exp_t q3[$];
    int   xv[4];
    int   br[$], bc[$], bv[$];

    always #5 clk = ~clk;

    sparse_mvm_core #(.DIM(4), .DW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_row(in_row), .in_col(in_col), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .nnz_count(nnz_count), .err(err));

    sparse_mvm_core #(.DIM(3), .DW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .in_data(d3_in_data), .in_row(d3_in_row), .in_col(d3_in_col), .in_last(d3_in_last),
        .out_valid(d3_out_valid), .out_ready(1'b1), .out_data(d3_out_data),
        .out_idx(d3_out_idx), .busy(d3_busy), .nnz_count(d3_nnz), .err(d3_err));

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result element from the exact mathematical dot product.
    function automatic int reduce(input longint a);
`ifdef MVM_SAT_EN
        if (a > 127) return 127;
        if (a < -128) return -128;
        return int'(a);
`else
        longint w;
        w = a & 64'hFF;
        return (w > 127) ? int'(w - 256) : int'(w);
`endif
    endfunction

    task automatic send4(input int d, input int r, input int c, input int l);
        int n = 0;
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d[7:0]; in_row = r[1:0]; in_col = c[1:0]; in_last = l[0];
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send3(input int d, input int r, input int c, input int l);
        d3_in_valid = 1'b1; d3_in_data = d[7:0]; d3_in_row = r[1:0]; d3_in_col = c[1:0]; d3_in_last = l[0];
        check("d3_in_ready", d3_in_ready, 1);
        @(posedge clk); #1;
        d3_in_valid = 1'b0; d3_in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin @(posedge clk); n++; end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Load xv, push the reference result, then stream the beats in br/bc/bv.
    task automatic run_mat();
        longint y[4];
        int nnz = 0;
        for (int i = 0; i < 4; i++) y[i] = 0;
        for (int k = 0; k < br.size(); k++) begin
            if (bv[k] != 0) begin
                y[br[k]] += longint'(bv[k]) * longint'(xv[bc[k]]);
                nnz = (nnz < 16) ? nnz + 1 : 16;
            end
        end
        for (int i = 0; i < 4; i++) q.push_back('{i, reduce(y[i]), nnz});
        for (int i = 0; i < 4; i++) send4(xv[i], 0, 0, 0);
        for (int k = 0; k < br.size(); k++) send4(bv[k], br[k], bc[k], (k == br.size() - 1) ? 1 : 0);
        drain();
        check("err_main", err, 0);
    endtask

    task automatic set_beats(input int rr[], input int cc[], input int vv[]);
        br.delete(); bc.delete(); bv.delete();
        foreach (rr[k]) begin br.push_back(rr[k]); bc.push_back(cc[k]); bv.push_back(vv[k]); end
    endtask

    task automatic identity_run();
        xv = '{1, 2, 3, 4};
        set_beats('{0, 1, 2, 3}, '{0, 1, 2, 3}, '{1, 1, 1, 1});
        run_mat();
    endtask

    // out_ready driver: always-ready, random, or a 3-cycle stall at index 1.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && out_idx == 2'd1 && stall < 3) begin
                        out_ready = 1'b0; stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Main monitor: every presented element must match the head of the scoreboard.
    initial begin
        bit post_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (post_last) begin
                    check("nnz_after_drain", nnz_count, 0);
                    check("busy_after_drain", busy, 0);
                    check("in_ready_after_drain", in_ready, 1);
                    post_last = 1'b0;
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_out_valid", 1, 0);
                    end else begin
                        check("out_idx", out_idx, q[0].idx);
                        check("out_data", int'($signed(out_data)), q[0].data);
                        check("nnz_count", nnz_count, q[0].nnz);
                        check("in_ready_in_out", in_ready, 0);
                        if (out_ready) begin
                            if (q[0].idx == 3) post_last = 1'b1;
                            void'(q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // DIM=3 monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && d3_out_valid) begin
                if (q3.size() == 0) begin
                    check("d3_spurious_out_valid", 1, 0);
                end else begin
                    check("d3_out_idx", d3_out_idx, q3[0].idx);
                    check("d3_out_data", int'($signed(d3_out_data)), q3[0].data);
                    check("d3_nnz", d3_nnz, q3[0].nnz);
                    void'(q3.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; in_row = 2'd0; in_col = 2'd0;
        d3_in_valid = 1'b0; d3_in_last = 1'b0; d3_in_data = 8'd0; d3_in_row = 2'd0; d3_in_col = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_nnz", nnz_count, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        identity_run();

        xv = '{-3, 0, 0, 0};
        set_beats('{0}, '{0}, '{5});
        run_mat();

        xv = '{127, 0, 0, 0};
        set_beats('{0, 0}, '{0, 0}, '{127, 127});
        run_mat();

        rdy_mode = 2; stall = 0;
        xv = '{10, -20, 30, -40};
        set_beats('{0, 1, 2, 3, 1}, '{3, 2, 1, 0, 1}, '{2, 3, -1, 1, 4});
        run_mat();
        check("stall_cycles", stall, 3);
        rdy_mode = 0;

        for (int i = 0; i < 4; i++) send4(i + 1, 0, 0, 0);
        send4(7, 0, 0, 0);
        send4(9, 1, 1, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_nnz", nnz_count, 0);
        check("midrst_err", err, 0);
        identity_run();

        rdy_mode = 1;
        for (int r = 0; r < 25; r++) begin
            int nb;
            for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
            br.delete(); bc.delete(); bv.delete();
            nb = int'($urandom_range(1, 12));
            for (int k = 0; k < nb; k++) begin
                br.push_back(int'($urandom_range(0, 3)));
                bc.push_back(int'($urandom_range(0, 3)));
                bv.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)) - 128);
            end
            run_mat();
        end
        rdy_mode = 0;

        q3.push_back('{0, 0, 1});
        q3.push_back('{1, 8, 1});
        q3.push_back('{2, 0, 1});
        send3(1, 0, 0, 0);
        send3(1, 0, 0, 0);
        send3(2, 0, 0, 0);
        send3(0, 0, 0, 0);
        send3(9, 3, 1, 0);
        check("d3_err_set", d3_err, 1);
        send3(4, 1, 2, 1);
        repeat (10) @(posedge clk);
        #1;
        check("d3_drained", q3.size(), 0);
        check("d3_err_sticky", d3_err, 1);
        check("d3_busy_idle", d3_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sparse_mvm_core.md
Name: sparse_mvm_core

Overview:
- Parametrised sparse matrix-vector multiply engine; successor to the fixed 8-bit MVM accelerator behind the TinyTapeout top.
- Loads a DIM-element input vector, then accepts only the nonzero matrix entries as (row, col, value) beats and accumulates y[row] += A[row][col]*x[col].
- Streams the DIM-element result vector out with a valid/ready handshake.
- Sits between the pad-level byte interface (ui_in / uio_*) and uo_out in the top wrapper.

Parameters:
- DIM, 4, vector length and matrix dimension (2..8).
- DW, 8, data width of vector, matrix and output elements; signed two's complement.
- IW, $clog2(DIM), row/col/index width (minimum 1).
- ACC_W, 2*DW+$clog2(DIM)+1, accumulator width per row.
- CW, $clog2(DIM*DIM+1), width of nnz_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  core accepts input beat
- in_data  in  DW  vector element (S_VEC) or matrix value (S_MAT)
- in_row  in  IW  matrix row index (S_MAT only)
- in_col  in  IW  matrix column index (S_MAT only)
- in_last  in  1  final matrix beat (S_MAT only)
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  result element
- out_idx  out  IW  index of out_data
- busy  out  1  high in S_MAT and S_OUT
- nnz_count  out  CW  nonzero entries accumulated for the current matrix
- err  out  1  sticky: out-of-range index seen

Behaviour:
- One clock: clk. Reset: rst_n, synchronous, active-low, sampled on rising clk edge.
- Reset: state=S_VEC, x[], acc[], vidx, oidx, nnz_count, err all 0; in_ready=1, out_valid=0, out_data=0, out_idx=0, busy=0.
- Accept = in_valid & in_ready; emit = out_valid & out_ready.
- S_VEC: in_ready=1. Each accept writes x[vidx]=in_data and increments vidx; in_row/in_col/in_last ignored. On the DIM-th accept, vidx->0 and state->S_MAT next cycle.
- S_MAT: in_ready=1. Each accept:
  - in_row>=DIM or in_col>=DIM: beat discarded, err set (held until reset).
  - in_data==0: beat discarded, no count (sparsity skip).
  - Otherwise acc[in_row] += sign-extended in_data*x[in_col] (single-cycle combinational multiply, result visible the next cycle); nnz_count += 1, saturating at DIM*DIM.
  - Duplicate (row,col) beats accumulate again; no dedup.
  - in_last on an accepted beat (including a discarded one) -> S_OUT next cycle.
- S_OUT: in_ready=0, out_valid=1, out_idx=oidx, out_data=acc[oidx] reduced to DW (see Optional Feature). out_data and out_idx hold stable while out_ready=0.
  - Each emit increments oidx. The emit at oidx==DIM-1 clears acc[], oidx and nnz_count; state->S_VEC next cycle.
- Latency: first out_valid is the cycle after the in_last accept; one element per cycle under out_ready=1.
- x[] is overwritten only by the next S_VEC load; the vector must be reloaded for every matrix.
- Reset asserted in any state, including mid-S_MAT or mid-S_OUT, returns everything to reset values on that edge; partial accumulations are lost.
- ACC_W is sized so no accumulator overflow occurs for up to DIM*DIM beats without duplicates; duplicates wrap modulo 2^ACC_W.

Optional Feature:
- Macro: MVM_SAT_EN.
- Defined: out_data = acc clamped to [-(2^(DW-1)), 2^(DW-1)-1].
- Undefined: out_data = acc[DW-1:0] (two's-complement wrap).

Test Plan:
- Identity: DIM=4, x=[1,2,3,4], beats (0,0,1),(1,1,1),(2,2,1),(3,3,1 last) -> out (idx,data) = (0,1),(1,2),(2,3),(3,4); nnz_count=4 before the final emit; 0 after.
- Signed single entry: x=[-3,0,0,0], beat (0,0,5 last) -> out_data -15,0,0,0; nnz_count=1.
- Saturation: x=[127,0,0,0], beats (0,0,127),(0,0,127 last) -> out0=127 with MVM_SAT_EN; out0=0x02 (32258 mod 256) without; outputs 1..3 = 0.
- Backpressure: during S_OUT, out_ready low for 3 cycles at idx 1 -> out_valid stays 1, out_idx=1 and out_data unchanged; sequence resumes with idx 2 and no element is lost or repeated.
- Skip and range (DIM=3, IW=2): beats (0,0,0),(3,1,9),(1,2,4 last), x=[1,1,2] -> err=1, nnz_count=1, outputs 0,8,0.
- Reset mid-op: rst_n low for one cycle after 2 matrix beats -> next edge shows in_ready=1, busy=0, nnz_count=0, err=0; a fresh identity run reproduces scenario 1 exactly.
